// File: rtl/apb4_req_bridge_if.sv
// Signal bundle for apb4_req_bridge: the local command/response channel and
// the APB4 requester bus. The "master" modport is the bridge's view; the
// "slave" modport is the environment (local controller plus APB completer).
interface apb4_req_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Command channel
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic                    req_write_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [DATA_WIDTH/8-1:0] req_strb_i;
  logic [2:0]              req_prot_i;

  // Response channel
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    rsp_timeout_o;

  // APB4 requester outputs
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;

  // APB4 completer returns
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
    input  rsp_ready_i,
    input  pready, prdata, pslverr,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
    output rsp_ready_i,
    output pready, prdata, pslverr,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb4_req_bridge.sv
// apb4_req_bridge: APB4 requester that turns single valid/ready commands into
// APB4 transfers, one in flight at a time, and returns read data and error
// status on a valid/ready response channel.
//
// Optional watchdog: define APB4_REQ_TIMEOUT_EN to abort an ACCESS phase that
// sees pready low for TIMEOUT_CYCLES cycles. Without the macro ACCESS waits
// indefinitely and rsp_timeout_o stays 0.
//
// Every output comes straight from a flop; nothing is combinational from an
// input to an output.
module apb4_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,   // 8, 16 or 32
  parameter int TIMEOUT_CYCLES = 255   // 1..65535, watchdog builds only
) (
  input  logic               pclk,
  input  logic               presetn,
  apb4_req_bridge_if.master  bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;

  // Bus-facing registers
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;

  // Handshake and response registers
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  // High in the ACCESS cycle where the watchdog gives up on the completer.
  logic                    timeout_hit;

`ifdef APB4_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count ACCESS cycles with pready low; SETUP is the only way into ACCESS,
  // so clearing there clears on every entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !bus.pready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // The cycle being evaluated is itself counted, so the abort lands in the
  // TIMEOUT_CYCLES-th ACCESS cycle; pready in that cycle still wins.
  assign timeout_hit = (state_q == ACCESS) && !bus.pready &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // No watchdog in this build: the limit is kept only so both builds share
  // one parameter list.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  // Next-state, command capture and response capture.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        // req_ready_o is high in IDLE, so valid alone completes the handshake.
        if (bus.req_valid_i) begin
          paddr_d  = bus.req_addr_i;
          pwrite_d = bus.req_write_i;
          pwdata_d = bus.req_write_i ? bus.req_wdata_i : '0;
          pstrb_d  = bus.req_write_i ? bus.req_strb_i  : '0;
          pprot_d  = bus.req_prot_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Control outputs are decoded from the next state and registered, so
    // they line up with the state register and never glitch from inputs.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State, bus and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    // NOTE: the datapath registers are reset too, because the bus and
    // response outputs must read as zero straight out of reset.
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;
  assign bus.psel          = psel_q;
  assign bus.penable       = penable_q;
  assign bus.pwrite        = pwrite_q;
  assign bus.paddr         = paddr_q;
  assign bus.pwdata        = pwdata_q;
  assign bus.pstrb         = pstrb_q;
  assign bus.pprot         = pprot_q;

endmodule

// File: tb/tb_apb4_req_bridge.sv
// Self-checking bench for apb4_req_bridge. Stimulus pushes the expected
// response of each command into a queue; a monitor pops and compares on every
// response handshake. A small APB completer model answers with a configurable
// number of wait states. Inputs change and outputs are sampled on the falling
// clock edge. Watchdog cases run when APB4_REQ_TIMEOUT_EN is defined.
module tb_apb4_req_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  logic pclk;
  logic presetn;

  apb4_req_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb4_req_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   rsp_count = 0;
  exp_t exp_q[$];

  // Completer configuration
  int          cfg_waits     = 0;
  logic [31:0] cfg_rdata     = 32'h0;
  logic        cfg_err       = 1'b0;
  logic        cfg_addr_data = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // APB completer: pready after cfg_waits low cycles; junk on prdata/pslverr
  // and pready high whenever the bridge must ignore them.
  initial begin
    int acc_cnt;
    acc_cnt     = 0;
    bus.pready  = 1'b1;
    bus.prdata  = 32'hBAD0_BAD0;
    bus.pslverr = 1'b1;
    forever begin
      @(negedge pclk);
      if (bus.psel && bus.penable) begin
        if (acc_cnt >= cfg_waits) begin
          bus.pready  = 1'b1;
          bus.prdata  = cfg_addr_data ? {16'hC0DE, bus.paddr[15:0]} : cfg_rdata;
          bus.pslverr = cfg_err;
        end else begin
          bus.pready  = 1'b0;
          bus.prdata  = 32'hBAD0_BAD0;
          bus.pslverr = 1'b1;
        end
        acc_cnt++;
      end else begin
        acc_cnt     = 0;
        bus.pready  = 1'b1;
        bus.prdata  = 32'hBAD0_BAD0;
        bus.pslverr = 1'b1;
      end
    end
  end

  // Response monitor / scoreboard, plus the psel/penable relation.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #1;
      if (presetn && bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
          check("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
          check("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(e.to));
        end
        rsp_count++;
      end
      if (bus.penable) check("penable_without_psel", 64'(bus.psel), 64'd1);
    end
  end

  // Issue one command from a falling edge; returns on the SETUP falling edge.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic push, input exp_t e);
    int n;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.req_ready_o) check("issue_ready_wait", 64'd0, 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_write_i = wr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    bus.req_prot_i  = prot;
    if (push) exp_q.push_back(e);
    @(negedge pclk);
    // Scramble the command inputs: the bus must run from captured values.
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'hFFFF_FFF0;
    bus.req_write_i = ~wr;
    bus.req_wdata_i = 32'h0BAD_F00D;
    bus.req_strb_i  = 4'hA;
    bus.req_prot_i  = 3'b101;
  endtask

  // Wait (bounded) for rsp_valid_o, counting ACCESS cycles and checking paddr.
  task automatic wait_rsp(input logic [31:0] exp_addr, output int access_cycles);
    int n;
    n = 0;
    access_cycles = 0;
    while (!bus.rsp_valid_o && n < 200) begin
      if (bus.penable) begin
        access_cycles++;
        check("paddr_stable", 64'(bus.paddr), 64'(exp_addr));
      end
      @(negedge pclk);
      n++;
    end
    if (!bus.rsp_valid_o) check("rsp_valid_wait", 64'd0, 64'd1);
  endtask

  initial begin
    int   ac;
    int   cyc;
    int   acc;
    int   base;
    exp_t e;

    presetn         = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.req_prot_i  = '0;
    bus.rsp_ready_i = 1'b1;

    // Reset values
    repeat (2) @(negedge pclk);
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_penable", 64'(bus.penable), 64'd0);
    check("rst_pwrite", 64'(bus.pwrite), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rsp_flags", {62'd0, bus.rsp_err_o, bus.rsp_timeout_o}, 64'd0);
    check("rst_paddr", 64'(bus.paddr), 64'd0);
    check("rst_pwdata_pstrb_pprot", {25'd0, bus.pwdata, bus.pstrb, bus.pprot}, 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    presetn = 1'b1;
    @(negedge pclk);

    // Write, zero wait states
    cfg_waits = 0;
    cfg_rdata = 32'h1111_2222;
    cfg_err   = 1'b0;
    e = '{rdata: 32'h0, err: 1'b0, to: 1'b0};
    issue(32'h0, 1'b1, 32'h5, 4'hF, 3'b010, 1'b1, e);
    check("wr_setup_psel", 64'(bus.psel), 64'd1);
    check("wr_setup_penable", 64'(bus.penable), 64'd0);
    check("wr_setup_paddr", 64'(bus.paddr), 64'h0);
    check("wr_setup_pwdata", 64'(bus.pwdata), 64'h5);
    check("wr_setup_pwrite", 64'(bus.pwrite), 64'd1);
    check("wr_setup_pstrb", 64'(bus.pstrb), 64'hF);
    check("wr_setup_pprot", 64'(bus.pprot), 64'h2);
    check("wr_setup_req_ready", 64'(bus.req_ready_o), 64'd0);
    @(negedge pclk);
    check("wr_access_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd3);
    check("wr_access_pwdata", 64'(bus.pwdata), 64'h5);
    check("wr_access_paddr", 64'(bus.paddr), 64'h0);
    @(negedge pclk);
    check("wr_resp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("wr_resp_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd0);
    @(negedge pclk);
    check("wr_idle_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("wr_idle_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);

    // Read, three wait states
    cfg_waits = 3;
    cfg_rdata = 32'hDEAD_BEEF;
    e = '{rdata: 32'hDEAD_BEEF, err: 1'b0, to: 1'b0};
    issue(32'h40, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b1, e);
    check("rd_setup_pwrite", 64'(bus.pwrite), 64'd0);
    check("rd_setup_pwdata_zero", 64'(bus.pwdata), 64'd0);
    check("rd_setup_pstrb_zero", 64'(bus.pstrb), 64'd0);
    wait_rsp(32'h40, ac);
    check("rd_access_cycles", 64'(ac), 64'd4);
    check("rd_resp_paddr_hold", 64'(bus.paddr), 64'h40);
    @(negedge pclk);
    check("rd_idle_req_ready", 64'(bus.req_ready_o), 64'd1);

    // Error response with 5 cycles of response backpressure
    cfg_waits       = 0;
    cfg_rdata       = 32'hFEED_F00D;
    cfg_err         = 1'b1;
    bus.rsp_ready_i = 1'b0;
    e = '{rdata: 32'hFEED_F00D, err: 1'b1, to: 1'b0};
    issue(32'h1C, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, e);
    wait_rsp(32'h1C, ac);
    for (int i = 0; i < 6; i++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("bp_rsp_err", 64'(bus.rsp_err_o), 64'd1);
      check("bp_rsp_rdata", 64'(bus.rsp_rdata_o), 64'hFEED_F00D);
      check("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
      bus.rsp_ready_i = (i == 5);
      @(negedge pclk);
    end
    check("bp_after_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("bp_after_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    cfg_err = 1'b0;

`ifdef APB4_REQ_TIMEOUT_EN
    // Watchdog abort: pready never rises
    cfg_waits = 1000;
    e = '{rdata: 32'h0, err: 1'b1, to: 1'b1};
    issue(32'h200, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, e);
    wait_rsp(32'h200, ac);
    check("to_access_cycles", 64'(ac), 64'd4);
    check("to_rsp_timeout", 64'(bus.rsp_timeout_o), 64'd1);
    @(negedge pclk);

    // pready on the limit cycle completes normally
    cfg_waits = 3;
    cfg_rdata = 32'hCAFE_0004;
    e = '{rdata: 32'hCAFE_0004, err: 1'b0, to: 1'b0};
    issue(32'h204, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, e);
    wait_rsp(32'h204, ac);
    check("to_edge_access_cycles", 64'(ac), 64'd4);
    check("to_edge_rsp_timeout", 64'(bus.rsp_timeout_o), 64'd0);
    @(negedge pclk);
`endif

    // Reset in the middle of ACCESS; the pending read produces no response
    cfg_waits = 1000;
    e = '{rdata: 32'h0, err: 1'b0, to: 1'b0};
    issue(32'h80, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, e);
    repeat (2) @(negedge pclk);
    check("rst_mid_in_access", 64'(bus.penable), 64'd1);
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd0);
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("rst_rel_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_rel_psel", 64'(bus.psel), 64'd0);

    // Read after the reset completes normally
    cfg_waits = 1;
    cfg_rdata = 32'h1234_5678;
    e = '{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0};
    issue(32'h84, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, e);
    wait_rsp(32'h84, ac);
    check("post_rst_access_cycles", 64'(ac), 64'd2);
    @(negedge pclk);

    // Back-to-back: 8 reads, req_valid_i and rsp_ready_i held high
    cfg_waits       = 0;
    cfg_addr_data   = 1'b1;
    bus.rsp_ready_i = 1'b1;
    bus.req_addr_i  = 32'h100;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = 32'h0;
    bus.req_strb_i  = 4'h0;
    bus.req_prot_i  = 3'b000;
    bus.req_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = '{rdata: {16'hC0DE, 16'h0100 + 16'(4 * k)}, err: 1'b0, to: 1'b0};
      exp_q.push_back(e);
    end
    base = rsp_count;
    cyc  = 0;
    acc  = 0;
    while (cyc < 100) begin
      if (bus.req_ready_o && bus.req_valid_i) acc++;
      @(negedge pclk);
      cyc++;
      if (acc == 8) bus.req_valid_i = 1'b0;
      else          bus.req_addr_i  = 32'h100 + 32'(4 * acc);
      if (acc == 8 && bus.req_ready_o && rsp_count == base + 8) break;
    end
    check("b2b_accepts", 64'(acc), 64'd8);
    check("b2b_responses", 64'(rsp_count - base), 64'd8);
    check("b2b_cycles", 64'(cyc), 64'd32);
    cfg_addr_data = 1'b0;

    repeat (3) @(negedge pclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Last-resort bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

endmodule
